// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and handshaked memory results onto the single register-file write port.
// Latency: one cycle from issue decision to registered wEnable_o/wAddr_o/wData_o; queued memory results wait at least one cycle.
// Backpressure: the ALU side is never stalled; memReady_o drops while the FIFO is full, with no push-through on a same-cycle pop.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   aluValid_i/aluAddr_i/aluData_i    ALU result, always accepted
//   memValid_i/memReady_o/memAddr_i/memData_i   memory-side result with valid/ready handshake
//   wEnable_o/wAddr_o/wData_o         registered register-file write port (addr/data held when idle)
//   qAddr_i/fwdHit_o/fwdData_o        combinational forwarding lookup into the FIFO
//   count_o                           FIFO occupancy, killed entries included
//
// Build option: define WB_FWD_EN to include the forwarding lookup; without it fwdHit_o/fwdData_o are tied to 0.
module wb_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      aluValid_i,
   input  logic [ADDR_W-1:0]         aluAddr_i,
   input  logic [DATA_W-1:0]         aluData_i,
   input  logic                      memValid_i,
   output logic                      memReady_o,
   input  logic [ADDR_W-1:0]         memAddr_i,
   input  logic [DATA_W-1:0]         memData_i,
   output logic                      wEnable_o,
   output logic [ADDR_W-1:0]         wAddr_o,
   output logic [DATA_W-1:0]         wData_o,
   input  logic [ADDR_W-1:0]         qAddr_i,
   output logic                      fwdHit_o,
   output logic [DATA_W-1:0]         fwdData_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [DEPTH-1:0]  q_live;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;

   logic              alu_wr;
   logic              fifo_empty;
   logic              mem_acc;
   logic              mem_keep;
   logic              pop;
   logic              direct;
   logic              push;
   logic              issue_vld;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] issue_data;

   // Extra wrap bit in the pointers makes the difference the true occupancy.
   assign count_o    = wr_ptr - rd_ptr;
   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign fifo_empty = (count_o == '0);
   assign memReady_o = !rst && (count_o < FULL_CNT);

   assign alu_wr   = aluValid_i && (aluAddr_i != '0);
   assign mem_acc  = memValid_i && memReady_o;
   // Memory result is older than a same-cycle ALU write to the same register, so it is dropped.
   assign mem_keep = mem_acc && (memAddr_i != '0) && !(alu_wr && (memAddr_i == aluAddr_i));
   assign pop      = !alu_wr && !fifo_empty;
   assign direct   = !alu_wr && fifo_empty && mem_keep;
   assign push     = mem_keep && !direct;

   always_comb begin
      issue_vld  = 1'b0;
      issue_addr = aluAddr_i;
      issue_data = aluData_i;
      if (alu_wr) begin
         issue_vld = 1'b1;
      end else if (pop) begin
         // A killed head is still popped but leaves a bubble.
         issue_vld  = q_live[rd_idx];
         issue_addr = q_addr[rd_idx];
         issue_data = q_data[rd_idx];
      end else if (direct) begin
         issue_vld  = 1'b1;
         issue_addr = memAddr_i;
         issue_data = memData_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         q_live    <= '0;
         wEnable_o <= 1'b0;
         wAddr_o   <= '0;
         wData_o   <= '0;
      end else begin
         wEnable_o <= issue_vld;
         if (issue_vld) begin
            wAddr_o <= issue_addr;
            wData_o <= issue_data;
         end
         // Kill stale entries; unoccupied slots may be cleared too, which is harmless
         // because a push always sets the live bit of its slot.
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr && (q_addr[i] == aluAddr_i)) begin
               q_live[i] <= 1'b0;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) begin
            q_live[wr_idx] <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
         end
      end
   end

   // Payload storage needs no reset: occupancy and live bits qualify every read.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_addr[wr_idx] <= memAddr_i;
         q_data[wr_idx] <= memData_i;
      end
   end

`ifdef WB_FWD_EN
   // Scan oldest to newest so the newest live match wins.
   always_comb begin
      logic [AW-1:0] idx;
      fwdHit_o  = 1'b0;
      fwdData_o = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_idx + AW'(i);
         if (!rst && ((AW+1)'(i) < count_o) && q_live[idx] &&
             (qAddr_i != '0) && (q_addr[idx] == qAddr_i)) begin
            fwdHit_o  = 1'b1;
            fwdData_o = q_data[idx];
         end
      end
   end
`else
   logic unused_qaddr;
   assign unused_qaddr = ^qAddr_i;
   assign fwdHit_o     = 1'b0;
   assign fwdData_o    = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vector table followed by randomized traffic against a queue-based reference model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: memory offers are made regardless of memReady_o; the model decides acceptance.
module tb_wb_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;
`ifdef WB_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              aluValid_i;
   logic [ADDR_W-1:0] aluAddr_i;
   logic [DATA_W-1:0] aluData_i;
   logic              memValid_i;
   logic              memReady_o;
   logic [ADDR_W-1:0] memAddr_i;
   logic [DATA_W-1:0] memData_i;
   logic              wEnable_o;
   logic [ADDR_W-1:0] wAddr_o;
   logic [DATA_W-1:0] wData_o;
   logic [ADDR_W-1:0] qAddr_i;
   logic              fwdHit_o;
   logic [DATA_W-1:0] fwdData_o;
   logic [2:0]        count_o;

   wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .aluValid_i(aluValid_i), .aluAddr_i(aluAddr_i), .aluData_i(aluData_i),
      .memValid_i(memValid_i), .memReady_o(memReady_o), .memAddr_i(memAddr_i), .memData_i(memData_i),
      .wEnable_o(wEnable_o), .wAddr_o(wAddr_o), .wData_o(wData_o),
      .qAddr_i(qAddr_i), .fwdHit_o(fwdHit_o), .fwdData_o(fwdData_o), .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: an in-order list of pending writes ----------------
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      bit                live;
   } ent_t;

   ent_t              mq[$];
   logic              m_we;
   logic [ADDR_W-1:0] m_wa;
   logic [DATA_W-1:0] m_wd;

   task automatic model_step();
      bit   rdy, acc, alu, mem_ok, issued;
      ent_t h, e;
      rdy = !rst && (mq.size() < DEPTH);
      if (rst) begin
         mq.delete();
         m_we = 1'b0; m_wa = '0; m_wd = '0;
         return;
      end
      acc    = memValid_i && rdy;
      alu    = aluValid_i && (aluAddr_i != 0);
      mem_ok = acc && (memAddr_i != 0) && !(alu && memAddr_i == aluAddr_i);
      issued = 1'b0;
      m_we   = 1'b0;
      if (alu) begin
         foreach (mq[i]) if (mq[i].a == aluAddr_i) mq[i].live = 1'b0;
         m_we = 1'b1; m_wa = aluAddr_i; m_wd = aluData_i;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (h.live) begin
            m_we = 1'b1; m_wa = h.a; m_wd = h.d;
         end
      end else if (mem_ok) begin
         m_we = 1'b1; m_wa = memAddr_i; m_wd = memData_i;
         issued = 1'b1;
      end
      if (mem_ok && !issued) begin
         e.a = memAddr_i; e.d = memData_i; e.live = 1'b1;
         mq.push_back(e);
      end
   endtask

   function automatic logic [DATA_W:0] model_fwd();
      if (!FWD_EN || rst || qAddr_i == 0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].live && mq[i].a == qAddr_i) return {1'b1, mq[i].d};
      return '0;
   endfunction

   task automatic apply(input logic r, input logic av, input logic [3:0] aa, input logic [15:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md, input logic [3:0] qa);
      @(negedge clk);
      rst = r; aluValid_i = av; aluAddr_i = aa; aluData_i = ad;
      memValid_i = mv; memAddr_i = ma; memData_i = md; qAddr_i = qa;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- directed vectors (values observed after the edge of each row) ----------------
   typedef struct {
      logic        rst, av;
      logic [3:0]  aa;
      logic [15:0] ad;
      logic        mv;
      logic [3:0]  ma;
      logic [15:0] md;
      logic [3:0]  qa;
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic [2:0]  cnt;
      logic        rdy, hit;
      logic [15:0] fd;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [DATA_W:0] f;
      rst = 1'b1; aluValid_i = 0; aluAddr_i = 0; aluData_i = 0;
      memValid_i = 0; memAddr_i = 0; memData_i = 0; qAddr_i = 0;

      //                 rst av aa  ad        mv ma  md        qa | we wa  wd        cnt rdy hit fd
      tbl.push_back(vec_t'{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0, 0, 16'h0000}); // reset
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 3, 16'h1234, 0,   1, 3, 16'h1234, 0, 1, 0, 16'h0000}); // direct
      tbl.push_back(vec_t'{0, 1, 2, 16'hAAAA, 1, 5, 16'h5555, 5,   1, 2, 16'hAAAA, 1, 1, 1, 16'h5555});
      tbl.push_back(vec_t'{0, 1, 6, 16'h6666, 0, 0, 16'h0000, 5,   1, 6, 16'h6666, 1, 1, 1, 16'h5555});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 5, 16'h5555, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 5, 16'h5555, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 1, 16'h0101, 1, 2, 16'h0002, 0,   1, 1, 16'h0101, 1, 1, 0, 16'h0000}); // fill
      tbl.push_back(vec_t'{0, 1, 1, 16'h0101, 1, 3, 16'h0003, 0,   1, 1, 16'h0101, 2, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 1, 16'h0101, 1, 4, 16'h0004, 0,   1, 1, 16'h0101, 3, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 1, 16'h0101, 1, 5, 16'h0005, 0,   1, 1, 16'h0101, 4, 0, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 1, 16'h0101, 1, 6, 16'h0006, 4,   1, 1, 16'h0101, 4, 0, 1, 16'h0004}); // full: refused
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 6, 16'h0006, 0,   1, 2, 16'h0002, 3, 1, 0, 16'h0000}); // no push-through
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 3, 16'h0003, 2, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 4, 16'h0004, 1, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 5, 16'h0005, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 5, 16'h0005, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 8, 16'h0808, 1, 7, 16'h0001, 7,   1, 8, 16'h0808, 1, 1, 1, 16'h0001}); // kill
      tbl.push_back(vec_t'{0, 1, 7, 16'h0002, 0, 0, 16'h0000, 7,   1, 7, 16'h0002, 1, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 7, 16'h0002, 0, 1, 0, 16'h0000}); // bubble
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 7, 16'h0002, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 9, 16'h0909, 1, 4, 16'h0011, 4,   1, 9, 16'h0909, 1, 1, 1, 16'h0011}); // forwarding
      tbl.push_back(vec_t'{0, 1, 9, 16'h0909, 1, 4, 16'h0022, 4,   1, 9, 16'h0909, 2, 1, 1, 16'h0022});
      tbl.push_back(vec_t'{0, 1, 9, 16'h0909, 0, 0, 16'h0000, 0,   1, 9, 16'h0909, 2, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 1, 9, 16'h0909, 1,10, 16'h00AA, 4,   1, 9, 16'h0909, 3, 1, 1, 16'h0022});
      tbl.push_back(vec_t'{1, 1, 9, 16'h0909, 0, 0, 16'h0000, 4,   0, 0, 16'h0000, 0, 0, 0, 16'h0000}); // reset mid-stream
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 1, 0, 16'h0000});
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0,   0, 0, 16'h0000, 0, 1, 0, 16'h0000}); // mem to r0
      tbl.push_back(vec_t'{0, 1, 0, 16'h1111, 1, 0, 16'hFFFF, 0,   0, 0, 16'h0000, 0, 1, 0, 16'h0000}); // alu to r0
      tbl.push_back(vec_t'{0, 1, 3, 16'h3333, 1, 3, 16'h4444, 3,   1, 3, 16'h3333, 0, 1, 0, 16'h0000}); // same-reg conflict
      tbl.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3,   0, 3, 16'h3333, 0, 1, 0, 16'h0000});

      foreach (tbl[i]) begin
         vec_t t;
         t = tbl[i];
         apply(t.rst, t.av, t.aa, t.ad, t.mv, t.ma, t.md, t.qa);
         check($sformatf("vec%0d wEnable", i), 32'(wEnable_o), 32'(t.we));
         check($sformatf("vec%0d wAddr", i), 32'(wAddr_o), 32'(t.wa));
         check($sformatf("vec%0d wData", i), 32'(wData_o), 32'(t.wd));
         check($sformatf("vec%0d count", i), 32'(count_o), 32'(t.cnt));
         check($sformatf("vec%0d memReady", i), 32'(memReady_o), 32'(t.rdy));
         check($sformatf("vec%0d fwdHit", i), 32'(fwdHit_o), 32'(t.hit & FWD_EN));
         check($sformatf("vec%0d fwdData", i), 32'(fwdData_o), 32'(FWD_EN ? t.fd : 16'h0));
      end

      // ---------------- randomized traffic against the model ----------------
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         apply(($urandom_range(0, 249) == 0),
               ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 7)), 16'($urandom),
               ($urandom_range(0, 99) < 65), 4'($urandom_range(0, 7)), 16'($urandom),
               4'($urandom_range(0, 7)));
         f = model_fwd();
         check("rnd wEnable", 32'(wEnable_o), 32'(m_we));
         check("rnd wAddr", 32'(wAddr_o), 32'(m_wa));
         check("rnd wData", 32'(wData_o), 32'(m_wd));
         check("rnd count", 32'(count_o), 32'(mq.size()));
         check("rnd memReady", 32'(memReady_o), 32'(!rst && mq.size() < DEPTH));
         check("rnd fwdHit", 32'(fwdHit_o), 32'(f[DATA_W]));
         check("rnd fwdData", 32'(fwdData_o), 32'(f[DATA_W-1:0]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
